// File: rtl/fb_writer.sv
// fb_writer: queues pixel writes and frame fills, then issues them to the SDRAM/VGA controller one word at a time.
// Latency: an accepted in-range pixel strobes the controller 2 cycles later when the queue is empty and lock=0.
// Backpressure: px_ready falls when the pixel FIFO is full or a fill is pending; lock=1 holds further strobes.
//
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   px_x/px_y/px_color      pixel coordinate and RGB565 value, qualified by px_valid/px_ready
//   clr_start/clr_color     one-cycle request to fill the whole frame with clr_color
//   clr_busy                a fill is pending or in progress
//   drop_cnt                saturating count of accepted pixels that were out of range
//   address/wr_data/rdwr    write request to the controller (rdwr is always 1 = write)
//   clk                     one-cycle request strobe to the controller
//   lock                    controller busy; no access is accepted while it is 1

// First-word-fall-through FIFO: pop_dat always shows the oldest entry while empty=0.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: pushes while full are discarded, so the caller gates them with full.
module fb_writer_fifo #(
    parameter int unsigned DW = 38,
    parameter int unsigned AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    // The count never exceeds DEPTH = 2^AW, so its top bit alone means full.
    assign full    = cnt_q[AW];
    assign empty   = (cnt_q == '0);
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_vld && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

module fb_writer #(
    parameter int unsigned WIDTH   = 640,
    parameter int unsigned HEIGHT  = 480,
    parameter logic [21:0] BASE    = 22'h0,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  px_x,
    input  logic [8:0]  px_y,
    input  logic [15:0] px_color,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic        clr_start,
    input  logic [15:0] clr_color,
    output logic        clr_busy,
    output logic [7:0]  drop_cnt,
    output logic [21:0] address,
    output logic [15:0] wr_data,
    output logic        rdwr,
    output logic        clk,
    input  logic        lock
);

    localparam logic [18:0] FILL_LAST = 19'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [21:0] address_q, address_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        clk_q, clk_d;
    logic        clr_busy_q, clr_busy_d;
    logic [15:0] clr_color_q, clr_color_d;
    logic [18:0] fill_cnt_q, fill_cnt_d;
    logic        fill_issued_q, fill_issued_d;  // every fill word of this clear has been strobed
    logic        cur_fill_q, cur_fill_d;        // in-flight word came from the fill counter
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        px_acc;
    logic        px_in_range;
    logic [21:0] row_off;
    logic [21:0] px_addr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [37:0] fifo_dat;
    logic        fill_avail;

    // Row offset: the default 640-wide frame uses two shifts instead of a multiplier.
    generate
        if (WIDTH == 640) begin : g_row_640
            assign row_off = 22'({px_y, 9'b0}) + 22'({px_y, 7'b0});
        end else begin : g_row_mul
            assign row_off = 22'(px_y) * 22'(WIDTH);
        end
    endgenerate

    assign px_addr     = BASE + row_off + 22'(px_x);
    assign px_in_range = (32'(px_x) < WIDTH) && (32'(px_y) < HEIGHT);
    assign px_ready    = !fifo_full && !clr_busy_q;
    assign px_acc      = px_valid && px_ready;

    fb_writer_fifo #(
        .DW (38),
        .AW (FIFO_AW)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (px_acc && px_in_range),
        .push_dat ({px_addr, px_color}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Fill words are only sourced once the FIFO is drained; px_ready is low
    // for the whole fill, so nothing can slip in behind them.
    assign fill_avail = clr_busy_q && !fill_issued_q && fifo_empty;

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        wr_data_d     = wr_data_q;
        clk_d         = 1'b0;
        clr_busy_d    = clr_busy_q;
        clr_color_d   = clr_color_q;
        fill_cnt_d    = fill_cnt_q;
        fill_issued_d = fill_issued_q;
        cur_fill_d    = cur_fill_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_pop      = 1'b0;

        if (px_acc && !px_in_range && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        // A clear request while one is already pending is dropped.
        if (clr_start && !clr_busy_q) begin
            clr_busy_d    = 1'b1;
            clr_color_d   = clr_color;
            fill_cnt_d    = '0;
            fill_issued_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!lock) begin
                    if (!fifo_empty) begin
                        address_d  = fifo_dat[37:16];
                        wr_data_d  = fifo_dat[15:0];
                        fifo_pop   = 1'b1;
                        cur_fill_d = 1'b0;
                        clk_d      = 1'b1;
                        state_d    = S_ACK;
                    end else if (fill_avail) begin
                        address_d  = BASE + 22'(fill_cnt_q);
                        wr_data_d  = clr_color_q;
                        cur_fill_d = 1'b1;
                        clk_d      = 1'b1;
                        state_d    = S_ACK;
                        if (fill_cnt_q == FILL_LAST) begin
                            fill_issued_d = 1'b1;
                        end else begin
                            fill_cnt_d = fill_cnt_q + 19'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                // Wait for the controller to take the request; never re-strobe here.
                if (lock) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // lock falling commits the word held on address/wr_data.
                if (!lock) begin
                    state_d = S_IDLE;
                    if (cur_fill_q && fill_issued_q) begin
                        clr_busy_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            address_q     <= '0;
            wr_data_q     <= '0;
            clk_q         <= 1'b0;
            clr_busy_q    <= 1'b0;
            clr_color_q   <= '0;
            fill_cnt_q    <= '0;
            fill_issued_q <= 1'b0;
            cur_fill_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            wr_data_q     <= wr_data_d;
            clk_q         <= clk_d;
            clr_busy_q    <= clr_busy_d;
            clr_color_q   <= clr_color_d;
            fill_cnt_q    <= fill_cnt_d;
            fill_issued_q <= fill_issued_d;
            cur_fill_q    <= cur_fill_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // A strobe registered on the edge before reset rises would otherwise
    // still be visible during the reset cycle; mask it so no request leaks out.
    assign clk      = clk_q && !reset;
    assign address  = address_q;
    assign wr_data  = wr_data_q;
    assign clr_busy = clr_busy_q;
    assign drop_cnt = drop_cnt_q;
    assign rdwr     = 1'b1;

endmodule

// File: tb/tb_fb_writer.sv
module tb_fb_writer;

    localparam int          W     = 640;
    localparam int          H     = 4;
    localparam logic [21:0] BASE  = 22'h0;
    localparam int          TOTAL = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  px_x = '0;
    logic [8:0]  px_y = '0;
    logic [15:0] px_color = '0;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic        clr_start = 1'b0;
    logic [15:0] clr_color = '0;
    logic        clr_busy;
    logic [7:0]  drop_cnt;
    logic [21:0] address;
    logic [15:0] wr_data;
    logic        rdwr;
    logic        wr_stb;
    logic        lock;
    logic        lock_m = 1'b0;
    logic        lock_force = 1'b0;

    assign lock = lock_m | lock_force;

    fb_writer #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .BASE    (BASE),
        .FIFO_AW (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_color  (px_color),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .drop_cnt  (drop_cnt),
        .address   (address),
        .wr_data   (wr_data),
        .rdwr      (rdwr),
        .clk       (wr_stb),
        .lock      (lock)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [21:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_drop = 0;
    int  cyc = 0;
    int  strobes = 0;
    int  last_commit = 0;

    // Controller model state.
    bit          active = 0;
    bit          pend = 0;
    bit          no_ack = 0;
    bit          busy_rand = 0;
    int          busy_len = 7;
    int          busy_left = 0;
    logic [21:0] cap_a = '0;
    logic [15:0] cap_d = '0;
    wr_t         mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(posedge clock) cyc++;

    // Controller model + monitor: pops the scoreboard on every strobe, raises
    // lock one cycle later for busy_left cycles, checks the request was held.
    always @(negedge clock) begin
        if (reset) begin
            active    = 0;
            pend      = 0;
            lock_m    = 1'b0;
            busy_left = 0;
        end else if (wr_stb) begin
            strobes++;
            chk("restrobe", 64'(active), 64'd0);
            chk("expected_write", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(address), 64'(mon_e.a));
                chk("wr_data", 64'(wr_data), 64'(mon_e.d));
            end
            active = 1;
            pend   = 1;
            cap_a  = address;
            cap_d  = wr_data;
        end else if (active) begin
            if (pend) begin
                pend = 0;
                if (!no_ack) begin
                    lock_m    = 1'b1;
                    busy_left = busy_rand ? int'($urandom_range(1, 7)) : busy_len;
                end
            end else if (lock_m) begin
                busy_left--;
                if (busy_left <= 0) begin
                    lock_m = 1'b0;
                    chk("hold_addr", 64'(address), 64'(cap_a));
                    chk("hold_data", 64'(wr_data), 64'(cap_d));
                    last_commit = cyc;
                    active = 0;
                end
            end
        end
    end

    // Reference model: what an accepted pixel should produce.
    task automatic model_accept(input int x, input int y, input logic [15:0] c);
        wr_t e;
        if (x < W && y < H) begin
            e.a = 22'(int'(BASE) + y * W + x);
            e.d = c;
            exp_q.push_back(e);
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
    endtask

    task automatic push_fill(input logic [15:0] c);
        wr_t e;
        for (int i = 0; i < TOTAL; i++) begin
            e.a = BASE + 22'(i);
            e.d = c;
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send_px(input int x, input int y, input logic [15:0] c);
        bit done = 0;
        px_x     = 10'(x);
        px_y     = 9'(y);
        px_color = c;
        px_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (px_ready) begin
                @(posedge clock);
                model_accept(x, y, c);
                done = 1;
            end
            @(negedge clock);
        end
        px_valid = 1'b0;
        if (!done) chk("px_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic px_and_clr(input int x, input int y, input logic [15:0] pc, input logic [15:0] cc);
        bit rdy;
        bit bsy;
        px_x      = 10'(x);
        px_y      = 9'(y);
        px_color  = pc;
        px_valid  = 1'b1;
        clr_color = cc;
        clr_start = 1'b1;
        rdy = px_ready;
        bsy = clr_busy;
        chk("simul_ready", 64'(rdy), 64'd1);
        chk("simul_not_busy", 64'(bsy), 64'd0);
        @(posedge clock);
        if (rdy) model_accept(x, y, pc);
        if (!bsy) push_fill(cc);
        @(negedge clock);
        px_valid  = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic do_clr(input logic [15:0] c);
        bit bsy;
        bsy = clr_busy;
        clr_color = c;
        clr_start = 1'b1;
        @(posedge clock);
        if (!bsy) push_fill(c);
        @(negedge clock);
        clr_start = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || active) && n < bound) begin
            @(negedge clock);
            n++;
        end
        chk("drain", 64'(exp_q.size() == 0 && !active), 64'd1);
    endtask

    initial begin
        #(600_000 * 10);
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int pulses;
        int n;

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_clk_during", 64'(wr_stb), 64'd0);
        reset = 1'b0;
        chk("rst_clk", 64'(wr_stb), 64'd0);
        chk("rst_clr_busy", 64'(clr_busy), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_px_ready", 64'(px_ready), 64'd1);
        chk("rst_rdwr", 64'(rdwr), 64'd1);

        // Single pixel, lock held 7 cycles; expected address 2*640+3 = 1283.
        s0 = strobes;
        send_px(3, 2, 16'hF800);
        wait_drain(100);
        chk("single_strobes", 64'(strobes - s0), 64'd1);
        chk("single_addr_1283", 64'(cap_a), 64'd1283);

        // 17 pixels against a held lock: FIFO fills at 16, order kept.
        lock_force = 1'b1;
        for (int i = 0; i < 16; i++) send_px(i * 7, i % H, 16'(16'h1000 + i));
        chk("ready_low_full", 64'(px_ready), 64'd0);
        px_x = 10'd33; px_y = 9'd3; px_color = 16'h2222; px_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("ready_still_low", 64'(px_ready), 64'd0);
        lock_force = 1'b0;
        busy_len = 1;
        send_px(33, 3, 16'h2222);
        wait_drain(400);

        // Randomized pixels with random lock durations and gaps.
        busy_rand = 1;
        for (int i = 0; i < 150; i++) begin
            send_px(int'($urandom_range(0, 700)), int'($urandom_range(0, 5)), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        wait_drain(2000);
        chk("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        busy_rand = 0;

        // Out-of-range pixels only: no writes, drop count saturates.
        s0 = strobes;
        send_px(640, 0, 16'h1234);
        for (int i = 0; i < 300; i++)
            send_px(int'($urandom_range(0, 1023)), (i % 2) ? 480 : int'($urandom_range(H, 511)), 16'($urandom));
        repeat (10) @(negedge clock);
        chk("drop_no_strobe", 64'(strobes - s0), 64'd0);
        chk("drop_cnt_model", 64'(drop_cnt), 64'(exp_drop));
        chk("drop_cnt_sat", 64'(drop_cnt), 64'd255);

        // Fill: two queued pixels, a third together with clr_start, then the frame.
        busy_len = 1;
        lock_force = 1'b1;
        send_px(10, 1, 16'hAAAA);
        send_px(11, 2, 16'hBBBB);
        px_and_clr(12, 3, 16'hCCCC, 16'h001F);
        chk("fill_busy", 64'(clr_busy), 64'd1);
        chk("fill_ready_low", 64'(px_ready), 64'd0);
        lock_force = 1'b0;
        repeat (20) @(negedge clock);
        do_clr(16'hBEEF);
        n = 0;
        while (clr_busy && n < 20000) begin
            @(negedge clock);
            n++;
        end
        chk("clr_busy_fell", 64'(clr_busy), 64'd0);
        chk("clr_fall_timing", 64'(cyc - last_commit), 64'd1);
        chk("fill_all_written", 64'(exp_q.size()), 64'd0);
        wait_drain(100);

        // Long lock after a strobe: no second strobe until it falls.
        busy_len = 100;
        s0 = strobes;
        send_px(5, 1, 16'h0F0F);
        send_px(6, 1, 16'hF0F0);
        repeat (60) @(negedge clock);
        chk("long_lock_one_strobe", 64'(strobes - s0), 64'd1);
        wait_drain(600);
        chk("long_lock_both", 64'(strobes - s0), 64'd2);

        // Reset while waiting in ACK with words still queued.
        busy_len = 1;
        no_ack = 1;
        s0 = strobes;
        send_px(7, 0, 16'h0007);
        send_px(8, 0, 16'h0008);
        send_px(9, 0, 16'h0009);
        repeat (10) @(negedge clock);
        chk("ack_wait_one_strobe", 64'(strobes - s0), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        pulses = 0;
        repeat (3) begin
            @(negedge clock);
            if (wr_stb) pulses++;
        end
        reset = 1'b0;
        no_ack = 0;
        repeat (20) begin
            @(negedge clock);
            if (wr_stb) pulses++;
        end
        chk("reset_no_pulse", 64'(pulses), 64'd0);
        chk("reset_fifo_empty", 64'(strobes - s0), 64'd1);
        chk("post_rst_ready", 64'(px_ready), 64'd1);
        chk("post_rst_busy", 64'(clr_busy), 64'd0);
        chk("post_rst_drop", 64'(drop_cnt), 64'd0);
        chk("post_rst_addr", 64'(address), 64'd0);

        // Normal operation resumes after reset.
        send_px(1, 1, 16'hABCD);
        wait_drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter WIDTH, default 640, pixels per line.
REQ-002 Parameter HEIGHT, default 480, lines per frame.
REQ-003 Parameter BASE, default 22'h0, word address of pixel (0,0).
REQ-004 Parameter FIFO_AW, default 4, log2 pixel FIFO depth (16 entries).
REQ-005 clock  in  1  100 MHz clock; same clock as the SDRAM/VGA controller; sole clock of the block.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 px_x  in  10  pixel column.
REQ-008 px_y  in  9  pixel row.
REQ-009 px_color  in  16  RGB565 pixel value.
REQ-010 px_valid  in  1  pixel offered.
REQ-011 px_ready  out  1  pixel accepted on the cycle where px_valid and px_ready are both 1.
REQ-012 clr_start  in  1  one-cycle request to fill the whole frame.
REQ-013 clr_color  in  16  fill value; sampled with clr_start.
REQ-014 clr_busy  out  1  fill pending or in progress.
REQ-015 drop_cnt  out  8  saturating count of out-of-range pixels.
REQ-016 address  out  22  word address to controller.
REQ-017 wr_data  out  16  write data to controller (controller i_data).
REQ-018 rdwr  out  1  constant 1 (write).
REQ-019 clk  out  1  one-cycle request strobe to controller.
REQ-020 lock  in  1  controller busy; 1 = no access accepted.

Function
REQ-021 The pixel FIFO SHALL be first-word-fall-through, storing {address, data}, depth 2^FIFO_AW.
REQ-022 px_ready SHALL equal FIFO-not-full AND NOT clr_busy.
REQ-023 Address SHALL be BASE + px_y*WIDTH + px_x, computed modulo 2^22; for WIDTH=640, px_y*640 is implemented as (px_y<<9)+(px_y<<7).
REQ-024 An accepted pixel with px_x>=WIDTH or px_y>=HEIGHT SHALL NOT be enqueued, and drop_cnt SHALL increment, saturating at 255.
REQ-025 The FSM SHALL have states IDLE, ACK and BUSY.
REQ-026 In IDLE with lock=0 and a word available, the FSM SHALL register address/wr_data, drive clk=1 for exactly one cycle, and enter ACK.
REQ-027 In ACK, on lock=1 the FSM SHALL enter BUSY; while lock=0 it SHALL remain in ACK without re-strobing clk.
REQ-028 In BUSY, on lock=0 the write SHALL count as committed and the FSM SHALL return to IDLE; a new strobe is allowed no earlier than the following cycle.
REQ-029 address and wr_data SHALL stay stable from the strobe cycle until the commit.
REQ-030 The FIFO entry SHALL be popped on the strobe cycle.
REQ-031 clr_start with clr_busy=0 SHALL set clr_busy=1 the next cycle and latch clr_color; clr_start while clr_busy=1 SHALL be ignored.
REQ-032 During a fill, FIFO entries already queued SHALL be written first.
REQ-033 Fill words SHALL then go to BASE .. BASE+WIDTH*HEIGHT-1 in ascending order, one per handshake, using a 19-bit counter.
REQ-034 clr_busy SHALL fall the cycle after the last fill word commits.
REQ-035 Simultaneous px_valid (with px_ready=1) and clr_start SHALL enqueue the pixel before the fill begins.

Reset
REQ-036 On reset: FSM=IDLE, FIFO empty, clk=0, clr_busy=0, drop_cnt=0, address=0, wr_data=0, px_ready=1 (next cycle), rdwr=1.
REQ-037 Reset mid-handshake or mid-fill SHALL abandon the operation; clk SHALL NOT pulse during or on the cycle after reset.

Verification
REQ-038 Pixel (x=3, y=2, color 16'hF800) with lock=0, controller model raising lock 1 cycle after clk for 7 cycles -> one clk pulse, address=22'd1283, wr_data=16'hF800, held until lock falls.
REQ-039 Push 17 pixels while lock=1 -> px_ready low after the 16th; release lock -> 16 ordered writes, then the 17th.
REQ-040 Pixel (x=640, y=0) and 300 pixels with y=480 -> no clk pulses, drop_cnt=255.
REQ-041 Two queued pixels then clr_start with clr_color=16'h001F -> the 2 pixels are written, then 307200 fill writes 0..307199; clr_busy drops after the last commit.
REQ-042 lock held 1 for 100 cycles after a strobe -> no second strobe; reset asserted in ACK -> clk stays 0 and FIFO is empty afterwards.
